sr_joy_reader: RTL and testbench

// Reads two 12-button pads from the UserIO port through a serial parallel-in shift-register chain.

---
 rtl/joy_pkg.sv | 16 +
 rtl/joy_tick_gen.sv | 17 +
 rtl/sr_joy_reader.sv | 115 +++++++++++
 tb/tb_sr_joy_reader.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
// joy_pkg: shared state type and pad bit positions for the serial joystick reader
package joy_pkg;
  typedef enum logic [2:0] {LOAD, LATCH, SHIFT_LO, SHIFT_HI, DONE, GAP} sr_state_t;
  localparam int JB_R   = 0;
  localparam int JB_L   = 1;
  localparam int JB_D   = 2;
  localparam int JB_U   = 3;
  localparam int JB_A   = 4;
  localparam int JB_B   = 5;
  localparam int JB_C   = 6;
  localparam int JB_DB  = 7;
  localparam int JB_E   = 8;
  localparam int JB_F   = 9;
  localparam int JB_ST  = 10;
  localparam int JB_SEL = 11;
endpackage

// File: rtl/joy_tick_gen.sv
// joy_tick_gen: one-clk tick every CLK_DIV clocks
module joy_tick_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == CW'(CLK_DIV - 1);
  always_comb cnt_d = tick ? '0 : cnt_q + CW'(1);
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/sr_joy_reader.sv
// sr_joy_reader: scans two pads through a serial shift-register chain and debounces the result
module sr_joy_reader
  import joy_pkg::*;
#(
  parameter int CLK_DIV   = 16,
  parameter int NBITS     = 12,
  parameter int GAP_TICKS = 64,
  parameter int DEB_SCANS = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  input  logic        JOY_DATA,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        scan_done
);
  localparam int NB2 = 2 * NBITS;
  localparam int BW  = $clog2(NB2);
  localparam int GW  = GAP_TICKS > 1 ? $clog2(GAP_TICKS) : 1;
  localparam int SW  = DEB_SCANS > 1 ? $clog2(DEB_SCANS) : 1;
  sr_state_t       state_q, state_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [NB2-1:0]  raw_q, raw_d, prev_q, prev_d;
  logic [SW-1:0]   stable_q, stable_d;
  logic [15:0]     joy1_q, joy1_d, joy2_q, joy2_d;
  logic            jclk_q, jclk_d, jload_q, jload_d, done_q, done_d;
  logic [1:0]      sync_q;
  logic            started_q, tick, tick_rst;
  // The tick phase restarts after reset and after DONE so every phase is a whole tick
  assign tick_rst = reset | ~started_q | (state_q == DONE);
  joy_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .reset(tick_rst), .tick(tick));
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    raw_d    = raw_q;
    prev_d   = prev_q;
    stable_d = stable_q;
    joy1_d   = joy1_q;
    joy2_d   = joy2_q;
    case (state_q)
      LOAD:     if (tick) state_d = LATCH;
      LATCH:    if (tick) begin
        state_d = SHIFT_LO;
        bit_d   = '0;
      end
      SHIFT_LO: if (tick) begin
        raw_d[bit_q] = sync_q[1];
        state_d      = SHIFT_HI;
      end
      SHIFT_HI: if (tick) begin
        bit_d   = bit_q + BW'(1);
        state_d = bit_q == BW'(NB2 - 1) ? DONE : SHIFT_LO;
      end
      DONE: begin
        stable_d = raw_q != prev_q ? '0 :
                   stable_q == SW'(DEB_SCANS - 1) ? stable_q : stable_q + SW'(1);
        prev_d   = raw_q;
        if (stable_d == SW'(DEB_SCANS - 1)) begin
          joy1_d = {4'b0, ~raw_q[JB_SEL:JB_R]};
          joy2_d = {4'b0, ~raw_q[NBITS+JB_SEL:NBITS+JB_R]};
        end
        gap_d   = '0;
        state_d = GAP;
      end
      GAP:      if (tick) begin
        gap_d   = gap_q + GW'(1);
        state_d = gap_q == GW'(GAP_TICKS - 1) ? LOAD : GAP;
      end
      default:  state_d = LOAD;
    endcase
    jclk_d  = state_d != SHIFT_LO;
    jload_d = state_d != LOAD;
    done_d  = state_q == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LOAD;
      bit_q     <= '0;
      gap_q     <= '0;
      raw_q     <= '0;
      prev_q    <= '0;
      stable_q  <= '0;
      joy1_q    <= '0;
      joy2_q    <= '0;
      jclk_q    <= 1'b1;
      jload_q   <= 1'b1;
      done_q    <= 1'b0;
      sync_q    <= 2'b11;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      raw_q     <= raw_d;
      prev_q    <= prev_d;
      stable_q  <= stable_d;
      joy1_q    <= joy1_d;
      joy2_q    <= joy2_d;
      jclk_q    <= jclk_d;
      jload_q   <= jload_d;
      done_q    <= done_d;
      sync_q    <= {sync_q[0], JOY_DATA};
      started_q <= 1'b1;
    end
  end
  assign JOY_CLK   = jclk_q;
  assign JOY_LOAD  = jload_q;
  assign joystick1 = joy1_q;
  assign joystick2 = joy2_q;
  assign scan_done = done_q;
endmodule

// File: tb/tb_sr_joy_reader.sv
// tb_sr_joy_reader: directed tests with a behavioural model of the two-pad shift-register chain
module tb_sr_joy_reader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        JOY_CLK, JOY_LOAD, JOY_DATA, scan_done;
  logic [15:0] joystick1, joystick2;
  logic [11:0] p1 = '0, p2 = '0;
  logic [23:0] chain = '1;
  logic        jclk_prev = 1'b1;
  logic        tie_en = 1'b0, tie_val = 1'b1;
  int          checks = 0, errors = 0;

  sr_joy_reader #(.CLK_DIV(4), .NBITS(12), .GAP_TICKS(4), .DEB_SCANS(2)) dut (
    .clk(clk), .reset(reset), .JOY_CLK(JOY_CLK), .JOY_LOAD(JOY_LOAD), .JOY_DATA(JOY_DATA),
    .joystick1(joystick1), .joystick2(joystick2), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  assign JOY_DATA = tie_en ? tie_val : chain[0];

  always @(negedge clk) begin
    if (!JOY_LOAD) chain <= {~p2, ~p1};
    else if (JOY_CLK && !jclk_prev) chain <= {1'b1, chain[23:1]};
    jclk_prev <= JOY_CLK;
  end

  task automatic wait_scan();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (scan_done) return;
    end
    $display("FAIL scan_timeout: no scan_done within 400 clks");
    $fatal(1, "scan_done timeout");
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (JOY_CLK !== 1'b1) begin errors++; $display("FAIL reset_joy_clk: got %b expected 1", JOY_CLK); end
    checks++; if (JOY_LOAD !== 1'b1) begin errors++; $display("FAIL reset_joy_load: got %b expected 1", JOY_LOAD); end
    checks++; if (joystick1 !== 16'h0000) begin errors++; $display("FAIL reset_joystick1: got %h expected 0000", joystick1); end
    checks++; if (joystick2 !== 16'h0000) begin errors++; $display("FAIL reset_joystick2: got %h expected 0000", joystick2); end
    checks++; if (scan_done !== 1'b0) begin errors++; $display("FAIL reset_scan_done: got %b expected 0", scan_done); end
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (JOY_LOAD === 1'b0) n++;
    end
    checks++; if (n != 4) begin errors++; $display("FAIL load_width: got %0d clks expected 4", n); end
  endtask

  task automatic test_timing();
    logic prev;
    int cyc, falls, low, high, bad_low, bad_high;
    wait_scan();
    prev = JOY_CLK; cyc = 0; falls = 0; low = 0; high = 0; bad_low = 0; bad_high = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cyc++;
      if (scan_done) break;
      if (JOY_CLK === 1'b0) begin
        if (prev) begin
          falls++;
          if (falls > 1 && high != 4) bad_high++;
          low = 0;
        end
        low++;
      end else begin
        if (!prev) begin
          if (low != 4) bad_low++;
          high = 0;
        end
        high++;
      end
      prev = JOY_CLK;
    end
    checks++; if (cyc != 217) begin errors++; $display("FAIL scan_period: got %0d clks expected 217", cyc); end
    checks++; if (falls != 24) begin errors++; $display("FAIL clk_falls: got %0d expected 24", falls); end
    checks++; if (bad_low != 0) begin errors++; $display("FAIL low_phase: got %0d bad phases expected 0", bad_low); end
    checks++; if (bad_high != 0) begin errors++; $display("FAIL high_phase: got %0d bad phases expected 0", bad_high); end
  endtask

  task automatic test_mapping();
    p1 = 12'h011; p2 = 12'h400;
    wait_scan();
    checks++; if (joystick1 !== 16'h0000) begin errors++; $display("FAIL map_first_scan: got %h expected 0000", joystick1); end
    wait_scan();
    checks++; if (joystick1 !== 16'h0011) begin errors++; $display("FAIL map_joystick1: got %h expected 0011", joystick1); end
    checks++; if (joystick2 !== 16'h0400) begin errors++; $display("FAIL map_joystick2: got %h expected 0400", joystick2); end
  endtask

  task automatic test_debounce();
    p1 = '0; p2 = '0;
    wait_scan(); wait_scan();
    checks++; if (joystick1 !== 16'h0000 || joystick2 !== 16'h0000) begin errors++; $display("FAIL deb_release: got %h/%h expected 0000/0000", joystick1, joystick2); end
    p1 = 12'h008;
    wait_scan();
    p1 = '0;
    checks++; if (joystick1 !== 16'h0000) begin errors++; $display("FAIL deb_bounce: got %h expected 0000", joystick1); end
    wait_scan();
    checks++; if (joystick1 !== 16'h0000) begin errors++; $display("FAIL deb_after_bounce: got %h expected 0000", joystick1); end
    p1 = 12'h008;
    wait_scan();
    checks++; if (joystick1 !== 16'h0000) begin errors++; $display("FAIL deb_hold1: got %h expected 0000", joystick1); end
    wait_scan();
    checks++; if (joystick1 !== 16'h0008) begin errors++; $display("FAIL deb_hold2: got %h expected 0008", joystick1); end
  endtask

  task automatic test_disconnected();
    tie_en = 1'b1; tie_val = 1'b1;
    wait_scan();
    checks++; if (joystick1 !== 16'h0008) begin errors++; $display("FAIL disc_hi_first: got %h expected 0008", joystick1); end
    wait_scan();
    checks++; if (joystick1 !== 16'h0000 || joystick2 !== 16'h0000) begin errors++; $display("FAIL disc_hi: got %h/%h expected 0000/0000", joystick1, joystick2); end
    tie_val = 1'b0;
    wait_scan();
    checks++; if (joystick1 !== 16'h0000) begin errors++; $display("FAIL disc_lo_first: got %h expected 0000", joystick1); end
    wait_scan();
    checks++; if (joystick1 !== 16'h0fff || joystick2 !== 16'h0fff) begin errors++; $display("FAIL disc_lo: got %h/%h expected 0fff/0fff", joystick1, joystick2); end
    tie_en = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    logic prev;
    int falls;
    bit seen;
    p1 = 12'h008; p2 = '0;
    wait_scan(); wait_scan();
    checks++; if (joystick1 !== 16'h0008) begin errors++; $display("FAIL mid_pre: got %h expected 0008", joystick1); end
    prev = JOY_CLK; falls = 0;
    for (int i = 0; i < 400 && falls < 11; i++) begin
      @(negedge clk);
      if (prev && JOY_CLK === 1'b0) falls++;
      prev = JOY_CLK;
    end
    checks++; if (falls != 11) begin errors++; $display("FAIL mid_falls: got %0d expected 11", falls); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (joystick1 !== 16'h0000 || joystick2 !== 16'h0000) begin errors++; $display("FAIL mid_outputs: got %h/%h expected 0000/0000", joystick1, joystick2); end
    checks++; if (JOY_CLK !== 1'b1 || JOY_LOAD !== 1'b1) begin errors++; $display("FAIL mid_lines: got clk=%b load=%b expected 1/1", JOY_CLK, JOY_LOAD); end
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (JOY_LOAD === 1'b0) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_reload: got no JOY_LOAD low expected low within 5 clks"); end
    wait_scan();
    checks++; if (joystick1 !== 16'h0000) begin errors++; $display("FAIL mid_scan1: got %h expected 0000", joystick1); end
    wait_scan();
    checks++; if (joystick1 !== 16'h0008) begin errors++; $display("FAIL mid_scan2: got %h expected 0008", joystick1); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_mapping();
    test_debounce();
    test_disconnected();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
